u765_sd_arb: RTL and testbench
==============================

# u765_sd_arb

Two-port arbiter sharing the single host SD block interface (sd_lba / sd_rd / sd_wr / sd_ack / buffer bus) between two disk-image requesters. Typical pairing: two u765 FDC instances, or u765 plus a tape/other image loader. Each block transfer is granted atomically: request capture, host strobe, ack window, release. Round-robin fairness; hung-host timeout.

## Interface
- TIMEOUT, 24'hFFFFFF, cycles in GRANT without sd_ack before abort (24-bit counter)
- clk_sys  in  1  system clock; all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- rq0_lba, rq1_lba  in  32  requester block address; stable while request bits set
- rq0_rd, rq1_rd  in  2  per-drive read request, level
- rq0_wr, rq1_wr  in  2  per-drive write request, level
- rq0_ack, rq1_ack  out  1  sd_ack & (grant==i), combinational
- rq0_buff_din, rq1_buff_din  in  8  requester write data
- rq0_buff_wr, rq1_buff_wr  out  1  sd_buff_wr & (grant==i), combinational
- sd_lba  out  32  latched address of granted request
- sd_rd, sd_wr  out  2  host strobes, registered
- sd_ack  in  1  host transfer-active
- sd_buff_addr, sd_buff_dout, sd_buff_wr  in  9/8/1  host buffer bus; addr/dout fanned to both requesters unchanged
- sd_buff_din  out  8  rq{grant}_buff_din, combinational; 0 when IDLE
- grant  out  2  one-hot owner; 0 in IDLE
- err  out  1  one-cycle pulse on timeout abort

## Operation
- States: IDLE, GRANT, XFER.
- IDLE: requester i pending when |{rqi_rd,rqi_wr}. Both pending -> pick priority pointer ptr (reset 0). Capture lba and one strobe bit: rd preferred over wr, drive 0 over drive 1; others ignored this grant. Set grant, load sd_rd/sd_wr, clear counter -> GRANT.
- GRANT: sd_rd/sd_wr held. sd_ack=1 -> clear sd_rd/sd_wr, -> XFER. Counter reaches TIMEOUT -> clear strobes, grant=0, err=1 one cycle, ptr toggles, -> IDLE.
- XFER: strobes 0; buffer bus routed to owner. sd_ack=0 -> grant=0, ptr = ~owner, -> IDLE.
- Requester withdrawing bits during GRANT/XFER ignored; transfer completes.
- Owner still requesting on return to IDLE: re-eligible, but ptr favours other port if pending.
- sd_ack high while IDLE: ignored, no rqi_ack.
- Reset (any state): IDLE, ptr=0, all registered outputs 0.

## Timing
- Reset values: sd_lba=0, sd_rd=0, sd_wr=0, grant=0, err=0; combinational outputs 0 since grant=0.
- Request visible cycle n in IDLE -> sd_rd/sd_wr/sd_lba/grant valid cycle n+1.
- sd_ack rise sampled cycle m -> strobes 0 at m+1; rqi_ack follows sd_ack same cycle.
- sd_ack fall sampled cycle k -> grant=0 at k+1; next grant earliest k+2.
- Timeout: err pulses at cycle TIMEOUT+1 after GRANT entry.
- Buffer mux zero latency; host must not issue sd_buff_wr outside sd_ack.

## Configuration
- U765_SD_ARB_TIMEOUT_EN defined: counter, timeout abort, err as above.
- Undefined: no counter; GRANT waits indefinitely for sd_ack; err tied 0; TIMEOUT unused.

## Test plan
- Reset: reset_n=0 3 cycles mid-XFER -> all outputs 0, grant=0, next IDLE uses port 0 on simultaneous request.
- Single read: rq1_rd=2'b01, rq1_lba=32'h123 -> next cycle sd_rd=01, sd_lba=123, grant=10; sd_ack high 512 cycles -> rq1_ack mirrors, 512 sd_buff_wr pulses to rq1_buff_wr only.
- Contention: rq0_wr=10 and rq1_rd=01 same cycle, ptr=0 -> port0 served (sd_wr=10); after ack fall port1 served (sd_rd=01) without gap >2 cycles.
- Fairness: both hold requests for 4 transfers -> grant sequence 01,10,01,10.
- Write data: port0 write granted, rq0_buff_din=8'hA5 -> sd_buff_din=A5 during XFER; port1 data never appears.
- Timeout (macro on, TIMEOUT=16): rq0_rd=01, no sd_ack -> err pulse 17 cycles after GRANT entry, strobes 0, grant=0, pending rq1 granted next.

Source files
------------

// File: rtl/u765_sd_arb.sv
// u765_sd_arb: shares one host SD block interface between two disk-image
// requesters. Each block transfer is granted atomically (capture, strobe, ack
// window, release) with round-robin fairness between the two ports.
// Optional feature macro: U765_SD_ARB_TIMEOUT_EN enables the hung-host timeout
// counter, the abort path and the err pulse. Without it GRANT waits for
// sd_ack indefinitely and err is tied low.
module u765_sd_arb #(
  parameter int unsigned TIMEOUT = 24'hFFFFFF
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [31:0] rq0_lba,
  input  logic [31:0] rq1_lba,
  input  logic [1:0]  rq0_rd,
  input  logic [1:0]  rq1_rd,
  input  logic [1:0]  rq0_wr,
  input  logic [1:0]  rq1_wr,
  output logic        rq0_ack,
  output logic        rq1_ack,
  input  logic [7:0]  rq0_buff_din,
  input  logic [7:0]  rq1_buff_din,
  output logic        rq0_buff_wr,
  output logic        rq1_buff_wr,
  output logic [31:0] sd_lba,
  output logic [1:0]  sd_rd,
  output logic [1:0]  sd_wr,
  input  logic        sd_ack,
  input  logic [8:0]  sd_buff_addr,
  input  logic [7:0]  sd_buff_dout,
  input  logic        sd_buff_wr,
  output logic [7:0]  sd_buff_din,
  output logic [1:0]  grant,
  output logic        err
);

  localparam int unsigned LBA_W = 32;
  localparam int unsigned DRV_W = 2;
  localparam int unsigned GNT_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_XFER  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               ptr_q, ptr_d;
  logic [GNT_W-1:0]   grant_d;
  logic [DRV_W-1:0]   sd_rd_d, sd_wr_d;
  logic [LBA_W-1:0]   sd_lba_d;
  logic               err_d;
  logic               pend0, pend1, pick1;
  logic [DRV_W-1:0]   sel_rd, sel_wr;

  // Host address/read data reach the requesters directly at the top level.
  logic unused_host_bus;
  assign unused_host_bus = ^{sd_buff_addr, sd_buff_dout};

`ifdef U765_SD_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = 24;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  // Pending detection and round-robin winner selection for IDLE.
  assign pend0 = |{rq0_rd, rq0_wr};
  assign pend1 = |{rq1_rd, rq1_wr};
  assign pick1 = pend1 & (~pend0 | ptr_q);

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    grant_d  = grant;
    sd_rd_d  = sd_rd;
    sd_wr_d  = sd_wr;
    sd_lba_d = sd_lba;
    err_d    = 1'b0;
    sel_rd   = pick1 ? rq1_rd : rq0_rd;
    sel_wr   = pick1 ? rq1_wr : rq0_wr;
`ifdef U765_SD_ARB_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pend0 | pend1) begin
          sd_lba_d = pick1 ? rq1_lba : rq0_lba;
          grant_d  = pick1 ? 2'b10 : 2'b01;
          sd_rd_d  = '0;
          sd_wr_d  = '0;
          // One strobe bit per grant: read beats write, drive 0 beats drive 1.
          if (|sel_rd) sd_rd_d = sel_rd[0] ? 2'b01 : 2'b10;
          else         sd_wr_d = sel_wr[0] ? 2'b01 : 2'b10;
`ifdef U765_SD_ARB_TIMEOUT_EN
          cnt_d    = '0;
`endif
          state_d  = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (sd_ack) begin
          sd_rd_d = '0;
          sd_wr_d = '0;
          state_d = ST_XFER;
        end
`ifdef U765_SD_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT)) begin
          sd_rd_d = '0;
          sd_wr_d = '0;
          grant_d = '0;
          err_d   = 1'b1;
          ptr_d   = ~ptr_q;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      ST_XFER: begin
        if (!sd_ack) begin
          // Favour the port that did not own this transfer.
          ptr_d   = ~grant[1];
          grant_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        grant_d = '0;
        sd_rd_d = '0;
        sd_wr_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= 1'b0;
      grant   <= '0;
      sd_rd   <= '0;
      sd_wr   <= '0;
      sd_lba  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant   <= grant_d;
      sd_rd   <= sd_rd_d;
      sd_wr   <= sd_wr_d;
      sd_lba  <= sd_lba_d;
    end
  end

`ifdef U765_SD_ARB_TIMEOUT_EN
  // Timeout counter and abort pulse.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      cnt_q <= '0;
      err   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err   <= err_d;
    end
  end
`else
  logic unused_err_d;
  assign unused_err_d = err_d;
  assign err = 1'b0;
`endif

  // Zero-latency routing of ack and buffer bus to the owner.
  assign rq0_ack     = sd_ack & grant[0];
  assign rq1_ack     = sd_ack & grant[1];
  assign rq0_buff_wr = sd_buff_wr & grant[0];
  assign rq1_buff_wr = sd_buff_wr & grant[1];
  assign sd_buff_din = grant[0] ? rq0_buff_din :
                       grant[1] ? rq1_buff_din : 8'h00;

endmodule

// File: tb/tb_u765_sd_arb.sv
// Directed bench for u765_sd_arb: reset, single read, contention, fairness,
// write-data routing, strobe selection, reset mid-transfer and timeout.
module tb_u765_sd_arb;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic [31:0] rq0_lba, rq1_lba;
  logic [1:0]  rq0_rd, rq1_rd, rq0_wr, rq1_wr;
  logic        rq0_ack, rq1_ack;
  logic [7:0]  rq0_buff_din, rq1_buff_din;
  logic        rq0_buff_wr, rq1_buff_wr;
  logic [31:0] sd_lba;
  logic [1:0]  sd_rd, sd_wr;
  logic        sd_ack;
  logic [8:0]  sd_buff_addr;
  logic [7:0]  sd_buff_dout;
  logic        sd_buff_wr;
  logic [7:0]  sd_buff_din;
  logic [1:0]  grant;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

  u765_sd_arb #(.TIMEOUT(16)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .rq0_lba(rq0_lba), .rq1_lba(rq1_lba),
    .rq0_rd(rq0_rd), .rq1_rd(rq1_rd), .rq0_wr(rq0_wr), .rq1_wr(rq1_wr),
    .rq0_ack(rq0_ack), .rq1_ack(rq1_ack),
    .rq0_buff_din(rq0_buff_din), .rq1_buff_din(rq1_buff_din),
    .rq0_buff_wr(rq0_buff_wr), .rq1_buff_wr(rq1_buff_wr),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
    .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din),
    .grant(grant), .err(err)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  int cnt0, cnt1, ack_bad;
  logic [1:0] exp_seq [4];

  initial begin
    exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01; exp_seq[3] = 2'b10;
    reset_n = 1'b0;
    rq0_lba = 32'h0; rq1_lba = 32'h0;
    rq0_rd = '0; rq1_rd = '0; rq0_wr = '0; rq1_wr = '0;
    rq0_buff_din = 8'h11; rq1_buff_din = 8'h22;
    sd_ack = 1'b1; sd_buff_wr = 1'b1;
    sd_buff_addr = 9'h1AB; sd_buff_dout = 8'h3C;
    repeat (3) tick();

    // Reset state, with host ack/wr asserted: nothing routed.
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_sd_rd", 32'(sd_rd), 32'h0);
    check("rst_sd_wr", 32'(sd_wr), 32'h0);
    check("rst_sd_lba", sd_lba, 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_acks", 32'({rq1_ack, rq0_ack}), 32'h0);
    check("rst_buff_wr", 32'({rq1_buff_wr, rq0_buff_wr}), 32'h0);
    check("rst_buff_din", 32'(sd_buff_din), 32'h0);

    // sd_ack high while IDLE is ignored.
    reset_n = 1'b1;
    tick();
    check("idle_ack_acks", 32'({rq1_ack, rq0_ack}), 32'h0);
    check("idle_ack_grant", 32'(grant), 32'h0);
    sd_ack = 1'b0; sd_buff_wr = 1'b0;
    tick();

    // Single read from port 1.
    rq1_rd = 2'b01; rq1_lba = 32'h123;
    tick();
    check("rd1_sd_rd", 32'(sd_rd), 32'h1);
    check("rd1_sd_wr", 32'(sd_wr), 32'h0);
    check("rd1_lba", sd_lba, 32'h123);
    check("rd1_grant", 32'(grant), 32'h2);
    rq1_rd = 2'b00;
    tick();
    check("rd1_hold_sd_rd", 32'(sd_rd), 32'h1);
    check("rd1_hold_grant", 32'(grant), 32'h2);
    sd_ack = 1'b1; sd_buff_wr = 1'b1;
    cnt0 = 0; cnt1 = 0; ack_bad = 0;
    for (int i = 0; i < 512; i++) begin
      #1;
      if (rq0_buff_wr) cnt0++;
      if (rq1_buff_wr) cnt1++;
      if (rq1_ack !== sd_ack || rq0_ack !== 1'b0) ack_bad++;
      tick();
      if (i == 0) begin
        check("rd1_strobe_clr", 32'(sd_rd), 32'h0);
        check("rd1_xfer_grant", 32'(grant), 32'h2);
      end
    end
    check("rd1_wr_pulses1", 32'(cnt1), 32'd512);
    check("rd1_wr_pulses0", 32'(cnt0), 32'd0);
    check("rd1_ack_mirror", 32'(ack_bad), 32'd0);
    sd_ack = 1'b0; sd_buff_wr = 1'b0;
    tick();
    check("rd1_release", 32'(grant), 32'h0);
    check("rd1_idle_din", 32'(sd_buff_din), 32'h0);

    // Contention with ptr=0: port 0 write first, then port 1 read.
    rq0_wr = 2'b10; rq0_lba = 32'hAAAA_0000;
    rq1_rd = 2'b01; rq1_lba = 32'hBBBB_0001;
    rq0_buff_din = 8'hA5; rq1_buff_din = 8'h5A;
    tick();
    check("ct_grant0", 32'(grant), 32'h1);
    check("ct_sd_wr", 32'(sd_wr), 32'h2);
    check("ct_sd_rd", 32'(sd_rd), 32'h0);
    check("ct_lba0", sd_lba, 32'hAAAA_0000);
    sd_ack = 1'b1; sd_buff_wr = 1'b1; rq0_wr = 2'b00;
    tick();
    check("ct_wr_clr", 32'(sd_wr), 32'h0);
    check("ct_din", 32'(sd_buff_din), 32'hA5);
    check("ct_bwr", 32'({rq1_buff_wr, rq0_buff_wr}), 32'h1);
    repeat (3) begin
      tick();
      check("ct_din_hold", 32'(sd_buff_din), 32'hA5);
    end
    sd_ack = 1'b0; sd_buff_wr = 1'b0;
    tick();
    check("ct_gap", 32'(grant), 32'h0);
    tick();
    check("ct_grant1", 32'(grant), 32'h2);
    check("ct_sd_rd1", 32'(sd_rd), 32'h1);
    check("ct_lba1", sd_lba, 32'hBBBB_0001);
    sd_ack = 1'b1; rq1_rd = 2'b00;
    tick();
    sd_ack = 1'b0;
    tick();

    // Fairness: both ports hold requests over four transfers.
    rq0_rd = 2'b01; rq1_wr = 2'b01;
    for (int t = 0; t < 4; t++) begin
      tick();
      check("fair_grant", 32'(grant), 32'(exp_seq[t]));
      sd_ack = 1'b1;
      tick();
      sd_ack = 1'b0;
      tick();
    end
    rq0_rd = 2'b00; rq1_wr = 2'b00;
    tick();

    // Strobe selection: drive 1 write on port 1, then rd over wr on port 0.
    rq1_wr = 2'b10;
    tick();
    check("sel_wr_d1", 32'(sd_wr), 32'h2);
    check("sel_rd_none", 32'(sd_rd), 32'h0);
    rq1_wr = 2'b00; sd_ack = 1'b1;
    tick();
    sd_ack = 1'b0;
    tick();
    rq0_rd = 2'b11; rq0_wr = 2'b11;
    tick();
    check("sel_rd_pref", 32'(sd_rd), 32'h1);
    check("sel_wr_ign", 32'(sd_wr), 32'h0);
    rq0_rd = 2'b00; rq0_wr = 2'b00; sd_ack = 1'b1;
    tick();
    sd_ack = 1'b0;
    tick();

    // Reset for 3 cycles mid-XFER (ptr currently favours port 1).
    rq1_rd = 2'b10; rq1_lba = 32'hDEAD_BEEF;
    tick();
    sd_ack = 1'b1; rq1_rd = 2'b00;
    tick();
    reset_n = 1'b0;
    repeat (3) tick();
    check("mrst_grant", 32'(grant), 32'h0);
    check("mrst_lba", sd_lba, 32'h0);
    check("mrst_strobes", 32'({sd_rd, sd_wr}), 32'h0);
    check("mrst_ack", 32'({rq1_ack, rq0_ack}), 32'h0);
    reset_n = 1'b1; sd_ack = 1'b0;
    rq0_rd = 2'b01; rq1_rd = 2'b01;
    tick();
    check("mrst_ptr0", 32'(grant), 32'h1);
    rq0_rd = 2'b00; rq1_rd = 2'b00; sd_ack = 1'b1;
    tick();
    sd_ack = 1'b0;
    tick();

`ifdef U765_SD_ARB_TIMEOUT_EN
    // Timeout: no ack for port 0; err 17 cycles after GRANT entry.
    rq0_rd = 2'b01;
    tick();
    check("to_grant", 32'(grant), 32'h1);
    rq0_rd = 2'b00; rq1_rd = 2'b01;
    ack_bad = 0;
    for (int j = 1; j <= 17; j++) begin
      tick();
      if (j < 17 && (err !== 1'b0 || grant !== 2'b01)) ack_bad++;
    end
    check("to_early", 32'(ack_bad), 32'd0);
    check("to_err", 32'(err), 32'h1);
    check("to_grant_clr", 32'(grant), 32'h0);
    check("to_strobes", 32'({sd_rd, sd_wr}), 32'h0);
    tick();
    check("to_err_pulse", 32'(err), 32'h0);
    check("to_next", 32'(grant), 32'h2);
`else
    // Without timeout, GRANT waits for the host indefinitely.
    rq0_rd = 2'b01;
    tick();
    rq0_rd = 2'b00; rq1_rd = 2'b01;
    repeat (40) tick();
    check("nto_hold", 32'(grant), 32'h1);
    check("nto_err", 32'(err), 32'h0);
    check("nto_strobe", 32'(sd_rd), 32'h1);
`endif
    rq1_rd = 2'b00; sd_ack = 1'b1;
    tick();
    sd_ack = 1'b0;
    tick();
    check("end_idle", 32'(grant), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
